// File: rtl/stonyman_pixel_sequencer.sv
// Stonyman image sensor pixel-scan sequencer.
// Walks a ROWS x COLS frame: it selects each row and column through the
// sensor's pointer/value strobes, lets the pixel settle, then hands one ADC
// conversion per pixel to the ADC and waits for it to finish.
// Optional feature: define STONYMAN_ABORT_EN to honour frame_abort.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for frame_start
// SEL_ROW   | resp, incp (ROWSEL), resv, then incv x pixel_row
// SEL_COL   | resp (COLSEL), resv; column pointer back to 0
// SETTLE    | SETTLE_TICKS cycles for the pixel output to settle
// CAPTURE   | one-cycle adc_capture_start
// WAIT_DONE | waiting for adc_capture_done
// NEXT_COL  | incv x1 to step to the next column
// DONE      | one-cycle frame_done, busy already cleared
module stonyman_pixel_sequencer #(
  parameter int ROWS         = 112,
  parameter int COLS         = 112,
  parameter int PULSE_TICKS  = 4,
  parameter int SETTLE_TICKS = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       frame_abort,
  input  logic       adc_capture_done,
  output logic       adc_capture_start,
  output logic       resp,
  output logic       incp,
  output logic       resv,
  output logic       incv,
  output logic       busy,
  output logic       frame_done,
  output logic [6:0] pixel_row,
  output logic [6:0] pixel_col
);

  localparam logic [6:0] ROW_MAX = 7'(ROWS - 1);
  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [7:0] P_LOAD  = 8'(PULSE_TICKS - 1);
  localparam logic [7:0] S_LOAD  = 8'(SETTLE_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE, SEL_ROW, SEL_COL, SETTLE, CAPTURE, WAIT_DONE, NEXT_COL, DONE
  } state_t;

  // Strobe phase: LAUNCH raises the first strobe of a burst, HIGH and GAP
  // time the pulse and the low gap that must follow it.
  typedef enum logic [1:0] {PH_LAUNCH, PH_HIGH, PH_GAP} phase_t;

  state_t     state;
  phase_t     phase;
  logic [7:0] tmr;
  logic [7:0] step;
  logic [7:0] last_step;
  logic [3:0] strb;  // {incv, resv, incp, resp}

`ifndef STONYMAN_ABORT_EN
  logic unused_abort;
  assign unused_abort = frame_abort;
`endif

  assign resp = strb[0];
  assign incp = strb[1];
  assign resv = strb[2];
  assign incv = strb[3];

  // Strobe issued at position idx of the burst belonging to state st.
  function automatic logic [3:0] strobe_pat(input state_t st, input logic [7:0] idx);
    logic [3:0] pat;
    pat = 4'b0000;
    case (st)
      SEL_ROW: begin
        if (idx == 8'd0)      pat = 4'b0001;
        else if (idx == 8'd1) pat = 4'b0010;
        else if (idx == 8'd2) pat = 4'b0100;
        else                  pat = 4'b1000;
      end
      SEL_COL:  pat = (idx == 8'd0) ? 4'b0001 : 4'b0100;
      NEXT_COL: pat = 4'b1000;
      default:  pat = 4'b0000;
    endcase
    return pat;
  endfunction

  // Index of the final strobe in the current burst.
  always_comb begin
    last_step = 8'd0;
    case (state)
      SEL_ROW: last_step = 8'd2 + {1'b0, pixel_row};
      SEL_COL: last_step = 8'd1;
      default: last_step = 8'd0;
    endcase
  end

  // Sequencer state, strobe timing and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      phase             <= PH_LAUNCH;
      tmr               <= 8'd0;
      step              <= 8'd0;
      strb              <= 4'b0000;
      adc_capture_start <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      pixel_row         <= 7'd0;
      pixel_col         <= 7'd0;
    end else begin
      adc_capture_start <= 1'b0;
      frame_done        <= 1'b0;
`ifdef STONYMAN_ABORT_EN
      if (frame_abort && (state != IDLE)) begin
        state <= IDLE;
        phase <= PH_LAUNCH;
        tmr   <= 8'd0;
        step  <= 8'd0;
        strb  <= 4'b0000;
        busy  <= 1'b0;
      end else begin
`else
      begin
`endif
        case (state)
          IDLE: begin
            if (frame_start) begin
              pixel_row <= 7'd0;
              pixel_col <= 7'd0;
              busy      <= 1'b1;
              phase     <= PH_LAUNCH;
              step      <= 8'd0;
              state     <= SEL_ROW;
            end
          end
          SEL_ROW, SEL_COL, NEXT_COL: begin
            case (phase)
              PH_LAUNCH: begin
                strb  <= strobe_pat(state, step);
                tmr   <= P_LOAD;
                phase <= PH_HIGH;
              end
              PH_HIGH: begin
                if (tmr == 8'd0) begin
                  strb  <= 4'b0000;
                  tmr   <= P_LOAD;
                  phase <= PH_GAP;
                end else begin
                  tmr <= tmr - 8'd1;
                end
              end
              default: begin
                if (tmr != 8'd0) begin
                  tmr <= tmr - 8'd1;
                end else if (step != last_step) begin
                  // Next strobe of the burst rises right as the gap ends.
                  step  <= step + 8'd1;
                  strb  <= strobe_pat(state, step + 8'd1);
                  tmr   <= P_LOAD;
                  phase <= PH_HIGH;
                end else begin
                  step <= 8'd0;
                  case (state)
                    SEL_ROW: begin
                      // COLSEL resp follows the row burst without an extra idle cycle.
                      strb  <= 4'b0001;
                      tmr   <= P_LOAD;
                      phase <= PH_HIGH;
                      state <= SEL_COL;
                    end
                    SEL_COL: begin
                      pixel_col <= 7'd0;
                      tmr       <= S_LOAD;
                      phase     <= PH_LAUNCH;
                      state     <= SETTLE;
                    end
                    default: begin
                      if (pixel_col < COL_MAX) pixel_col <= pixel_col + 7'd1;
                      tmr   <= S_LOAD;
                      phase <= PH_LAUNCH;
                      state <= SETTLE;
                    end
                  endcase
                end
              end
            endcase
          end
          SETTLE: begin
            if (tmr == 8'd0) begin
              adc_capture_start <= 1'b1;
              state             <= CAPTURE;
            end else begin
              tmr <= tmr - 8'd1;
            end
          end
          CAPTURE: begin
            state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (adc_capture_done) begin
              if (pixel_col < COL_MAX) begin
                phase <= PH_LAUNCH;
                step  <= 8'd0;
                state <= NEXT_COL;
              end else if (pixel_row < ROW_MAX) begin
                pixel_row <= pixel_row + 7'd1;
                phase     <= PH_LAUNCH;
                step      <= 8'd0;
                state     <= SEL_ROW;
              end else begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= DONE;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stonyman_pixel_sequencer.sv
`timescale 1ns/1ps
// Bench for stonyman_pixel_sequencer: small 2x3 frame, ADC responder model,
// expected strobe counts and addresses derived from the frame geometry.
module tb_stonyman_pixel_sequencer;

  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int PT   = 2;
  localparam int ST   = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_start = 1'b0;
  logic       frame_abort = 1'b0;
  logic       model_done = 1'b0;
  logic       inj_done = 1'b0;
  logic       adc_capture_done;
  logic       adc_capture_start, resp, incp, resv, incv, busy, frame_done;
  logic [6:0] pixel_row, pixel_col;

  assign adc_capture_done = model_done | inj_done;

  stonyman_pixel_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .PULSE_TICKS(PT), .SETTLE_TICKS(ST)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_abort(frame_abort),
    .adc_capture_done(adc_capture_done), .adc_capture_start(adc_capture_start),
    .resp(resp), .incp(incp), .resv(resv), .incv(incv), .busy(busy),
    .frame_done(frame_done), .pixel_row(pixel_row), .pixel_col(pixel_col)
  );

  always #12.5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int adc_lat = 10;
  bit adc_rand = 1'b0;

  // Observed activity: 0 resp,1 incp,2 resv,3 incv,4 capture starts,5 frame_done
  int cnt [6] = '{0, 0, 0, 0, 0, 0};
  string nm [6] = '{"resp", "incp", "resv", "incv", "capture_start", "frame_done"};
  int onehot_err = 0, done_busy_err = 0, done_wide_err = 0, start_wide_err = 0;
  int hi_run = 0, lo_run = 0, min_high = 1000, max_high = 0, min_gap = 1000;
  int last_fall = -1000, min_cap_d = 1000, max_cap_d = 0;
  bit seen_fall = 1'b0;
  logic [13:0] addr_log [256];
  logic [3:0] prev_s = 4'b0;
  logic prev_start = 1'b0, prev_done = 1'b0;

  // Expected per-frame totals from the scan rules.
  function automatic int exp_cnt(input int k);
    case (k)
      0: return 2 * ROWS;
      1: return ROWS;
      2: return 2 * ROWS;
      3: return (ROWS * (ROWS - 1)) / 2 + ROWS * (COLS - 1);
      4: return ROWS * COLS;
      default: return 1;
    endcase
  endfunction

  // Monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [3:0] s;
    int d;
    s = {incv, resv, incp, resp};
    if (!reset) begin
      prev_s = 4'b0; hi_run = 0; lo_run = 0; seen_fall = 1'b0;
      prev_start = 1'b0; prev_done = 1'b0;
    end else begin
      if ($countones(s) > 1) onehot_err++;
      for (int k = 0; k < 4; k++) if (s[k] && !prev_s[k]) cnt[k]++;
      if (s != 4'b0) begin
        if (prev_s == 4'b0 && seen_fall && lo_run < min_gap) min_gap = lo_run;
        if (prev_s != 4'b0 && s != prev_s) min_gap = 0;
        hi_run++;
        lo_run = 0;
      end else begin
        if (prev_s != 4'b0) begin
          if (hi_run < min_high) min_high = hi_run;
          if (hi_run > max_high) max_high = hi_run;
          hi_run = 0;
          last_fall = cyc;
          seen_fall = 1'b1;
        end
        lo_run++;
      end
      if (adc_capture_start && !prev_start) begin
        addr_log[cnt[4] % 256] = {pixel_row, pixel_col};
        cnt[4]++;
        d = cyc - last_fall;
        if (d < min_cap_d) min_cap_d = d;
        if (d > max_cap_d) max_cap_d = d;
      end
      if (adc_capture_start && prev_start) start_wide_err++;
      if (frame_done) begin
        if (prev_done) done_wide_err++; else cnt[5]++;
        if (busy) done_busy_err++;
      end
      prev_s = s;
      prev_start = adc_capture_start;
      prev_done = frame_done;
    end
  end

  // ADC responder: done lands on the clock edge adc_lat cycles after the start.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && adc_capture_start) begin
        int lat;
        lat = adc_rand ? int'($urandom_range(2, 20)) : adc_lat;
        repeat (lat - 1) @(negedge clk);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) begin timed_out = 1'b0; break; end
    end
    if (timed_out) begin
      n_cmp++; n_fail++;
      $display("FAIL frame_done_timeout: got none, expected one within 3000 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #40;
    n_cmp++;
    if ({incv, resv, incp, resp} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {incv, resv, incp, resp}); end
    n_cmp++;
    if ({adc_capture_start, busy, frame_done} !== 3'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {adc_capture_start, busy, frame_done}); end
    n_cmp++;
    if ({pixel_row, pixel_col} !== 14'd0) begin n_fail++; $display("FAIL reset_addr: got %0d,%0d expected 0,0", pixel_row, pixel_col); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_frame_counts();
    int base [6];
    bit to;
    adc_rand = 1'b0;
    base = cnt;
    pulse_start();
    wait_frame_done(to);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (cnt[k] - base[k] !== exp_cnt(k)) begin
        n_fail++; $display("FAIL count_%s: got %0d expected %0d", nm[k], cnt[k] - base[k], exp_cnt(k));
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_frame: got %b expected 0", busy); end
  endtask

  task automatic test_addresses();
    int b;
    bit to;
    logic [13:0] e;
    adc_rand = 1'b1;
    b = cnt[4];
    pulse_start();
    wait_frame_done(to);
    adc_rand = 1'b0;
    for (int k = 0; k < ROWS * COLS; k++) begin
      e = {7'(k / COLS), 7'(k % COLS)};
      n_cmp++;
      if (addr_log[(b + k) % 256] !== e) begin
        n_fail++; $display("FAIL addr_%0d: got %0d,%0d expected %0d,%0d", k,
          addr_log[(b + k) % 256][13:7], addr_log[(b + k) % 256][6:0], e[13:7], e[6:0]);
      end
    end
  endtask

  task automatic test_timing();
    int c0, d;
    bit to;
    d = -1;
    c0 = cyc;
    frame_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (resp) begin d = cyc - c0; break; end
    end
    n_cmp++;
    if (d !== 2) begin n_fail++; $display("FAIL first_resp_delay: got %0d expected 2", d); end
    wait_frame_done(to);
    n_cmp++;
    if (min_high !== PT || max_high !== PT) begin n_fail++; $display("FAIL strobe_width: got %0d..%0d expected %0d", min_high, max_high, PT); end
    n_cmp++;
    if (min_gap !== PT) begin n_fail++; $display("FAIL strobe_gap: got %0d expected %0d", min_gap, PT); end
    n_cmp++;
    if (min_cap_d !== PT + ST || max_cap_d !== PT + ST) begin
      n_fail++; $display("FAIL capture_after_strobe: got %0d..%0d expected %0d", min_cap_d, max_cap_d, PT + ST);
    end
  endtask

  task automatic test_protocol_flags();
    n_cmp++;
    if (onehot_err !== 0) begin n_fail++; $display("FAIL strobe_onehot: got %0d overlaps expected 0", onehot_err); end
    n_cmp++;
    if (start_wide_err !== 0) begin n_fail++; $display("FAIL capture_start_width: got %0d long pulses expected 0", start_wide_err); end
    n_cmp++;
    if (done_wide_err !== 0) begin n_fail++; $display("FAIL frame_done_width: got %0d long pulses expected 0", done_wide_err); end
    n_cmp++;
    if (done_busy_err !== 0) begin n_fail++; $display("FAIL done_with_busy: got %0d expected 0", done_busy_err); end
  endtask

  task automatic test_mid_frame_noise();
    int base [6];
    int lf, since;
    bit got_done;
    logic [3:0] ps;
    base = cnt;
    lf = -1000;
    ps = 4'b0;
    got_done = 1'b0;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      inj_done = 1'b0;
      if (frame_done) begin got_done = 1'b1; break; end
      if ({incv, resv, incp, resp} == 4'b0 && ps != 4'b0) lf = cyc;
      ps = {incv, resv, incp, resp};
      since = cyc - lf;
      if (busy && $urandom_range(0, 5) == 0) frame_start = 1'b1;
      if (since >= PT && since <= PT + ST - 1 && $urandom_range(0, 2) == 0) inj_done = 1'b1;
    end
    frame_start = 1'b0;
    inj_done = 1'b0;
    n_cmp++;
    if (!got_done) begin n_fail++; $display("FAIL noise_frame_done: got none expected 1"); end
    repeat (8) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (cnt[k] - base[k] !== exp_cnt(k)) begin
        n_fail++; $display("FAIL noise_count_%s: got %0d expected %0d", nm[k], cnt[k] - base[k], exp_cnt(k));
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL noise_restart: got busy %b expected 0", busy); end
  endtask

  task automatic test_done_cycle_start();
    int b;
    bit seen;
    b = cnt[0];
    seen = 1'b0;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1'b1; break; end
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (!seen || busy !== 1'b0) begin n_fail++; $display("FAIL done_cycle_start_busy: got seen=%b busy=%b expected 1,0", seen, busy); end
    n_cmp++;
    if (cnt[0] - b !== exp_cnt(0)) begin n_fail++; $display("FAIL done_cycle_start_resp: got %0d expected %0d", cnt[0] - b, exp_cnt(0)); end
  endtask

  task automatic test_reset_mid_pulse();
    int base [6];
    bit hit, to;
    hit = 1'b0;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (incv) begin hit = 1'b1; break; end
    end
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (!hit || incv !== 1'b0) begin n_fail++; $display("FAIL reset_incv: got hit=%b incv=%b expected 1,0", hit, incv); end
    n_cmp++;
    if ({resp, incp, resv, busy, adc_capture_start, frame_done} !== 6'b0) begin
      n_fail++; $display("FAIL reset_mid_flags: got %b expected 000000", {resp, incp, resv, busy, adc_capture_start, frame_done});
    end
    n_cmp++;
    if ({pixel_row, pixel_col} !== 14'd0) begin n_fail++; $display("FAIL reset_mid_addr: got %0d,%0d expected 0,0", pixel_row, pixel_col); end
    repeat (2) @(negedge clk);
    base = cnt;
    reset = 1'b1;
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL first_start_after_reset: got busy %b expected 1", busy); end
    wait_frame_done(to);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (cnt[k] - base[k] !== exp_cnt(k)) begin
        n_fail++; $display("FAIL post_reset_count_%s: got %0d expected %0d", nm[k], cnt[k] - base[k], exp_cnt(k));
      end
    end
  endtask

  task automatic test_abort();
    int base [6];
    int b2, seen;
    bit to;
    adc_rand = 1'b0;
    base = cnt;
    seen = 0;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (adc_capture_start) seen++;
      if (seen == 2) break;
    end
    // Abort lands on the same edge as the second capture's done.
    repeat (adc_lat - 1) @(negedge clk);
    frame_abort = 1'b1;
    @(negedge clk);
    frame_abort = 1'b0;
`ifdef STONYMAN_ABORT_EN
    n_cmp++;
    if ({busy, frame_done, incv, resv, incp, resp} !== 6'b0) begin
      n_fail++; $display("FAIL abort_idle: got %b expected 000000", {busy, frame_done, incv, resv, incp, resp});
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (cnt[5] - base[5] !== 0) begin n_fail++; $display("FAIL abort_frame_done: got %0d expected 0", cnt[5] - base[5]); end
    n_cmp++;
    if (cnt[4] - base[4] !== 2) begin n_fail++; $display("FAIL abort_captures: got %0d expected 2", cnt[4] - base[4]); end
    b2 = cnt[4];
    pulse_start();
    wait_frame_done(to);
    n_cmp++;
    if (addr_log[b2 % 256] !== 14'd0) begin
      n_fail++; $display("FAIL abort_restart_addr: got %0d,%0d expected 0,0", addr_log[b2 % 256][13:7], addr_log[b2 % 256][6:0]);
    end
    n_cmp++;
    if (cnt[4] - b2 !== exp_cnt(4)) begin n_fail++; $display("FAIL abort_restart_captures: got %0d expected %0d", cnt[4] - b2, exp_cnt(4)); end
`else
    b2 = 0;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_ignored_busy: got %b expected 1", busy); end
    wait_frame_done(to);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (cnt[k] - base[k] !== exp_cnt(k)) begin
        n_fail++; $display("FAIL abort_ignored_count_%s: got %0d expected %0d", nm[k], cnt[k] - base[k], exp_cnt(k));
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_frame_counts();
    test_addresses();
    test_timing();
    test_protocol_flags();
    test_mid_frame_noise();
    test_done_cycle_start();
    test_reset_mid_pulse();
    test_abort();
    test_protocol_flags();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
